eth_latency_measurer_tx: RTL and testbench

- Transmit side of the latency measurer. On a trigger it builds one ICMP ping frame (Ethernet + IPv4 + ICMP) and streams it byte-wise on an AXI-Stream master.
- The frame layout is byte-exact to what the matching receiver checks, so a measurer pair interoperates.
- Header checksums are computed sequentially before transmission starts.
- Sits between the measurer control logic and the MAC TX FIFO, all in one clock domain.

---
 rtl/eth_latency_measurer_pkg.sv | 68 ++++++
 rtl/eth_latency_measurer_tx_fold.sv | 21 ++
 rtl/eth_latency_measurer_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_eth_latency_measurer_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_latency_measurer_pkg.sv
// Shared types and constants for the latency measurer TX path.
// Contents: FSM state enum, header byte offsets, fixed IPv4/Ethernet header
// fields, the packed header layout and byte/word accessors for it.
package eth_latency_measurer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        FOLD,
        SEND
    } state_e;

    localparam int unsigned ETH_HDR_LEN   = 14;
    localparam int unsigned IP_CSUM_OFS   = 24;
    localparam int unsigned ICMP_CSUM_OFS = 36;
    localparam int unsigned PING_ID_OFS   = 40;
    localparam int unsigned HDR_LEN       = 42;
    localparam int unsigned BYTE_IDX_W    = 6;
    localparam int unsigned IDX_W         = 16;
    localparam int unsigned IP_ACC_W      = 20;
    localparam int unsigned ICMP_ACC_W    = 18;
    localparam int unsigned SUM_CYCLES    = 9;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
    localparam logic [15:0] IP_TOTAL_LEN   = 16'h001C;
    localparam logic [15:0] IP_FLAGS       = 16'h4000;
    localparam logic [15:0] IP_TTL_PROTO   = 16'h4001;

    // Header in wire order: first field is the first byte on the wire.
    typedef struct packed {
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [15:0] ethertype;
        logic [15:0] ver_ihl_tos;
        logic [15:0] total_len;
        logic [15:0] frame_id;
        logic [15:0] flags;
        logic [15:0] ttl_proto;
        logic [15:0] ip_csum;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [7:0]  icmp_type;
        logic [7:0]  icmp_code;
        logic [15:0] icmp_csum;
        logic [15:0] log_id;
        logic [15:0] ping_id;
    } hdr_fields_t;

    // Byte view of the header; wire byte i lives at element HDR_LEN-1-i.
    typedef logic [HDR_LEN-1:0][7:0] hdr_bytes_t;

    // Big-endian 16-bit word starting at wire byte ofs.
    function automatic logic [15:0] hdr_word(hdr_bytes_t h, logic [BYTE_IDX_W-1:0] ofs);
        return {h[BYTE_IDX_W'(HDR_LEN - 1) - ofs], h[BYTE_IDX_W'(HDR_LEN - 2) - ofs]};
    endfunction

    // Wire byte idx of the frame; everything past the header is zero padding.
    function automatic logic [7:0] hdr_byte(hdr_bytes_t h, logic [IDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx < IDX_W'(HDR_LEN)) begin
            b = h[BYTE_IDX_W'(IDX_W'(HDR_LEN - 1) - idx)];
        end
        return b;
    endfunction

endpackage

// File: rtl/eth_latency_measurer_tx_fold.sv
// Folds a wide one's-complement accumulator into a 16-bit inverted checksum.
// Ports: sum    - raw accumulator (W bits, W > 16)
//        csum_c - combinational ~fold(sum)
module ones_complement_fold #(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0] sum,
    output logic [15:0]  csum_c
);

    logic [16:0] fold1;
    logic [16:0] fold2;

    // Second fold absorbs the carry the first one may produce.
    always_comb begin
        fold1  = 17'(sum[15:0]) + 17'(sum[W-1:16]);
        fold2  = 17'(fold1[15:0]) + 17'(fold1[16]);
        csum_c = ~fold2[15:0];
    end

endmodule

// File: rtl/eth_latency_measurer_tx.sv
// Transmit side of the latency measurer: on start, builds one ICMP ping frame
// (Ethernet + IPv4 + ICMP, zero padded to C_FRAME_SIZE) and streams it bytewise.
// Ports: clk, rst (sync, active high); mac_addr_dst/src, ip_addr_src/dst,
//        frame_id, log_id, ping_id - frame config, captured on accepted start;
//        start - trigger; busy - frame in progress; done - end-of-frame pulse;
//        m_axis_* - byte-wide AXI-Stream master.
// Optional: ETH_LATENCY_MEASURER_TX_COUNTER_EN adds tx_count (frames sent).
module eth_latency_measurer_tx
    import eth_latency_measurer_pkg::*;
#(
    parameter int unsigned C_MODE       = 0,
    parameter int unsigned C_FRAME_SIZE = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] mac_addr_dst,
    input  logic [47:0] mac_addr_src,
    input  logic [31:0] ip_addr_src,
    input  logic [31:0] ip_addr_dst,
    input  logic [15:0] frame_id,
    input  logic [15:0] log_id,
    input  logic [15:0] ping_id,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
`ifdef ETH_LATENCY_MEASURER_TX_COUNTER_EN
    ,
    output logic [31:0] tx_count
`endif
);

    localparam logic [7:0]       ICMP_TYPE = (C_MODE == 0) ? 8'h08 : 8'h00;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(C_FRAME_SIZE - 1);
    localparam logic [3:0]       SUM_LAST  = 4'(SUM_CYCLES - 1);

    state_e                  state_q, state_d;
    hdr_bytes_t              hdr_q, hdr_d;
    logic [IP_ACC_W-1:0]     ip_acc_q, ip_acc_d;
    logic [ICMP_ACC_W-1:0]   icmp_acc_q, icmp_acc_d;
    logic [3:0]              sum_idx_q, sum_idx_d;
    logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [7:0]              tdata_q, tdata_d;

    hdr_fields_t             cap;
    logic [BYTE_IDX_W-1:0]   ip_ofs;
    logic [BYTE_IDX_W-1:0]   icmp_ofs;
    logic [15:0]             ip_csum_c;
    logic [15:0]             icmp_csum_c;
    logic [IDX_W-1:0]        byte_nxt;

    // Header image of the live config inputs; checksums start at zero.
    always_comb begin
        cap.mac_dst     = mac_addr_dst;
        cap.mac_src     = mac_addr_src;
        cap.ethertype   = ETHERTYPE_IPV4;
        cap.ver_ihl_tos = IP_VER_IHL_TOS;
        cap.total_len   = IP_TOTAL_LEN;
        cap.frame_id    = frame_id;
        cap.flags       = IP_FLAGS;
        cap.ttl_proto   = IP_TTL_PROTO;
        cap.ip_csum     = 16'h0000;
        cap.ip_src      = ip_addr_src;
        cap.ip_dst      = ip_addr_dst;
        cap.icmp_type   = ICMP_TYPE;
        cap.icmp_code   = 8'h00;
        cap.icmp_csum   = 16'h0000;
        cap.log_id      = log_id;
        cap.ping_id     = ping_id;
    end

    // Word k of each checksum, skipping the checksum field itself.
    always_comb begin
        ip_ofs = BYTE_IDX_W'(ETH_HDR_LEN) + BYTE_IDX_W'({sum_idx_q, 1'b0});
        if (ip_ofs >= BYTE_IDX_W'(IP_CSUM_OFS)) begin
            ip_ofs = ip_ofs + BYTE_IDX_W'(2);
        end
        case (sum_idx_q)
            4'd0:    icmp_ofs = BYTE_IDX_W'(ICMP_CSUM_OFS - 2);
            4'd1:    icmp_ofs = BYTE_IDX_W'(PING_ID_OFS - 2);
            default: icmp_ofs = BYTE_IDX_W'(PING_ID_OFS);
        endcase
    end

    ones_complement_fold #(.W(IP_ACC_W)) u_ip_fold (
        .sum    (ip_acc_q),
        .csum_c (ip_csum_c)
    );

    ones_complement_fold #(.W(ICMP_ACC_W)) u_icmp_fold (
        .sum    (icmp_acc_q),
        .csum_c (icmp_csum_c)
    );

    assign byte_nxt = byte_idx_q + IDX_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        ip_acc_d   = ip_acc_q;
        icmp_acc_d = icmp_acc_q;
        sum_idx_d  = sum_idx_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;

        case (state_q)
            IDLE: begin
                // busy_q is still set in the done cycle, which blocks a start there.
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    hdr_d      = hdr_bytes_t'(cap);
                    ip_acc_d   = '0;
                    icmp_acc_d = '0;
                    sum_idx_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = SUM;
                end
            end
            SUM: begin
                ip_acc_d = ip_acc_q + IP_ACC_W'(hdr_word(hdr_q, ip_ofs));
                if (sum_idx_q < 4'd3) begin
                    icmp_acc_d = icmp_acc_q + ICMP_ACC_W'(hdr_word(hdr_q, icmp_ofs));
                end
                if (sum_idx_q == SUM_LAST) begin
                    state_d = FOLD;
                end else begin
                    sum_idx_d = sum_idx_q + 4'd1;
                end
            end
            FOLD: begin
                hdr_d[BYTE_IDX_W'(HDR_LEN - 1 - IP_CSUM_OFS)]   = ip_csum_c[15:8];
                hdr_d[BYTE_IDX_W'(HDR_LEN - 2 - IP_CSUM_OFS)]   = ip_csum_c[7:0];
                hdr_d[BYTE_IDX_W'(HDR_LEN - 1 - ICMP_CSUM_OFS)] = icmp_csum_c[15:8];
                hdr_d[BYTE_IDX_W'(HDR_LEN - 2 - ICMP_CSUM_OFS)] = icmp_csum_c[7:0];
                byte_idx_d = '0;
                tvalid_d   = 1'b1;
                tdata_d    = hdr_byte(hdr_q, '0);
                tlast_d    = 1'b0;
                state_d    = SEND;
            end
            SEND: begin
                if (tvalid_q && m_axis_tready) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = 8'h00;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        byte_idx_d = byte_nxt;
                        tdata_d    = hdr_byte(hdr_q, byte_nxt);
                        tlast_d    = (byte_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hdr_q      <= '0;
            ip_acc_q   <= '0;
            icmp_acc_q <= '0;
            sum_idx_q  <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            ip_acc_q   <= ip_acc_d;
            icmp_acc_q <= icmp_acc_d;
            sum_idx_q  <= sum_idx_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

`ifdef ETH_LATENCY_MEASURER_TX_COUNTER_EN
    logic [31:0] tx_count_q, tx_count_d;

    // Frames completed since reset; wraps naturally.
    always_comb begin
        tx_count_d = tx_count_q;
        if (done_q) begin
            tx_count_d = tx_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_d;
        end
    end

    assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_eth_latency_measurer_tx.sv
// Scoreboard bench: two DUTs (echo request / echo reply) run in lockstep on the
// same inputs; expected frames come from an RFC 1071 style reference model.
module tb_eth_latency_measurer_tx;

    localparam int unsigned FS = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] mac_dst, mac_src;
    logic [31:0] ip_src, ip_dst;
    logic [15:0] frame_id, log_id, ping_id;
    logic        start;
    logic        tready;
    logic        rand_ready;

    logic        busy0, done0, tlast0, tvalid0;
    logic [7:0]  tdata0;
    logic        busy1, done1, tlast1, tvalid1;
    logic [7:0]  tdata1;
`ifdef ETH_LATENCY_MEASURER_TX_COUNTER_EN
    logic [31:0] tx_count0, tx_count1;
`endif

    int vectors = 0;
    int miscompares = 0;

    // {last, byte for mode 0, byte for mode 1}
    logic [16:0] exp_q[$];
    int          byte_cnt;

    always #5 clk = ~clk;

    eth_latency_measurer_tx #(.C_MODE(0), .C_FRAME_SIZE(FS)) dut0 (
        .clk(clk), .rst(rst),
        .mac_addr_dst(mac_dst), .mac_addr_src(mac_src),
        .ip_addr_src(ip_src), .ip_addr_dst(ip_dst),
        .frame_id(frame_id), .log_id(log_id), .ping_id(ping_id),
        .start(start), .busy(busy0), .done(done0),
        .m_axis_tdata(tdata0), .m_axis_tlast(tlast0),
        .m_axis_tvalid(tvalid0), .m_axis_tready(tready)
`ifdef ETH_LATENCY_MEASURER_TX_COUNTER_EN
        , .tx_count(tx_count0)
`endif
    );

    eth_latency_measurer_tx #(.C_MODE(1), .C_FRAME_SIZE(FS)) dut1 (
        .clk(clk), .rst(rst),
        .mac_addr_dst(mac_dst), .mac_addr_src(mac_src),
        .ip_addr_src(ip_src), .ip_addr_dst(ip_dst),
        .frame_id(frame_id), .log_id(log_id), .ping_id(ping_id),
        .start(start), .busy(busy1), .done(done1),
        .m_axis_tdata(tdata1), .m_axis_tlast(tlast1),
        .m_axis_tvalid(tvalid1), .m_axis_tready(tready)
`ifdef ETH_LATENCY_MEASURER_TX_COUNTER_EN
        , .tx_count(tx_count1)
`endif
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Internet checksum over fr[lo..hi-1] (checksum field assumed zero).
    function automatic logic [15:0] inet_csum(input logic [7:0] fr [FS], int lo, int hi);
        int unsigned s = 0;
        for (int i = lo; i < hi; i += 2) s += {16'h0, fr[i], fr[i + 1]};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(~s);
    endfunction

    function automatic void build_frame(int mode, output logic [7:0] fr [FS]);
        logic [15:0] c;
        for (int i = 0; i < FS; i++) fr[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            fr[i]     = mac_dst[47 - 8 * i -: 8];
            fr[6 + i] = mac_src[47 - 8 * i -: 8];
        end
        fr[12] = 8'h08; fr[13] = 8'h00;
        fr[14] = 8'h45; fr[15] = 8'h00; fr[16] = 8'h00; fr[17] = 8'h1C;
        fr[18] = frame_id[15:8]; fr[19] = frame_id[7:0];
        fr[20] = 8'h40; fr[21] = 8'h00; fr[22] = 8'h40; fr[23] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            fr[26 + i] = ip_src[31 - 8 * i -: 8];
            fr[30 + i] = ip_dst[31 - 8 * i -: 8];
        end
        fr[34] = (mode == 0) ? 8'h08 : 8'h00;
        fr[38] = log_id[15:8];  fr[39] = log_id[7:0];
        fr[40] = ping_id[15:8]; fr[41] = ping_id[7:0];
        c = inet_csum(fr, 14, 34);
        fr[24] = c[15:8]; fr[25] = c[7:0];
        c = inet_csum(fr, 34, FS);
        fr[36] = c[15:8]; fr[37] = c[7:0];
    endfunction

    function automatic void push_expected();
        logic [7:0] f0 [FS];
        logic [7:0] f1 [FS];
        build_frame(0, f0);
        build_frame(1, f1);
        for (int i = 0; i < FS; i++) exp_q.push_back({(i == FS - 1), f0[i], f1[i]});
    endfunction

    // Monitor: compares every handshaked byte, AXIS hold rules and done pulses.
    logic       stall, exp_done;
    logic [8:0] prev;
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            stall    = 1'b0;
            exp_done = 1'b0;
            byte_cnt = 0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(tvalid0), 32'd1);
                check("hold_data", 32'({tlast0, tdata0}), 32'(prev));
            end
            if (done0 || done1 || exp_done) begin
                check("done0", 32'(done0), 32'(exp_done));
                check("done1", 32'(done1), 32'(exp_done));
            end
            exp_done = 1'b0;
            if (tvalid0 || tvalid1) check("lockstep_valid", 32'(tvalid1), 32'(tvalid0));
            if (tvalid0 && tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(tdata0), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d_m0", byte_cnt), 32'(tdata0), 32'(e[15:8]));
                    check($sformatf("byte%0d_m1", byte_cnt), 32'(tdata1), 32'(e[7:0]));
                    check($sformatf("tlast%0d_m0", byte_cnt), 32'(tlast0), 32'(e[16]));
                    check($sformatf("tlast%0d_m1", byte_cnt), 32'(tlast1), 32'(e[16]));
                    byte_cnt = e[16] ? 0 : byte_cnt + 1;
                    exp_done = e[16];
                end
            end
            stall = tvalid0 && !tready;
            prev  = {tlast0, tdata0};
        end
    end

    // Ready driver: always ready, or 50% random when rand_ready is set.
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(bit accept);
        start = 1'b1;
        if (accept) push_expected();
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((busy0 || busy1 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n >= budget), 32'd0);
        step();
    endtask

    task automatic basic_cfg(logic [15:0] pid);
        mac_dst  = 48'h0011_2233_4455;
        mac_src  = 48'h6677_8899_AABB;
        ip_src   = 32'hC0A8_0101;
        ip_dst   = 32'hC0A8_0102;
        frame_id = 16'h0000;
        log_id   = 16'h1234;
        ping_id  = pid;
    endtask

    task automatic random_cfg();
        mac_dst  = {16'($urandom), $urandom};
        mac_src  = {16'($urandom), $urandom};
        ip_src   = $urandom;
        ip_dst   = $urandom;
        frame_id = 16'($urandom);
        log_id   = 16'($urandom);
        ping_id  = 16'($urandom);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start      = 1'b0;
        rand_ready = 1'b0;
        basic_cfg(16'h0001);
        reset_dut();

        // Reset values
        check("rst_busy", 32'({busy1, busy0}), 32'd0);
        check("rst_done", 32'({done1, done0}), 32'd0);
        check("rst_tvalid", 32'({tvalid1, tvalid0}), 32'd0);
        check("rst_tlast", 32'({tlast1, tlast0}), 32'd0);
        check("rst_tdata", 32'({tdata1, tdata0}), 32'd0);

        // Basic frame with latency measurement
        do_start(1'b1);
        check("busy_after_start", 32'({busy1, busy0}), 32'h3);
        n = 1;
        while (!tvalid0 && n < 40) begin
            step();
            n++;
        end
        check("first_valid_latency", 32'(n), 32'd11);
        wait_idle(500);

        // Random ready, random configs changing while the frame is in flight
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            random_cfg();
            do_start(1'b1);
            random_cfg();
            wait_idle(2000);
        end
        basic_cfg(16'h0001);
        do_start(1'b1);
        wait_idle(2000);
        rand_ready = 1'b0;

        // Start during SEND and on the done cycle is ignored; next cycle accepted
        basic_cfg(16'h0001);
        do_start(1'b1);
        repeat (15) step();
        do_start(1'b0);
        n = 0;
        while (!done0 && n < 300) begin
            step();
            n++;
        end
        check("done_timeout", 32'(n >= 300), 32'd0);
        check("busy_in_done_cycle", 32'({busy1, busy0}), 32'h3);
        ping_id = 16'h0002;
        start   = 1'b1;
        step();
        push_expected();
        step();
        start = 1'b0;
        wait_idle(500);
        repeat (20) step();
        check("single_frame_idle", 32'({tvalid1, tvalid0}), 32'd0);

        // Reset at byte 20, then a clean frame
        basic_cfg(16'h0003);
        do_start(1'b1);
        n = 0;
        while (byte_cnt < 20 && n < 300) begin
            step();
            n++;
        end
        check("byte20_timeout", 32'(n >= 300), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_tvalid", 32'({tvalid1, tvalid0}), 32'd0);
        check("midrst_busy", 32'({busy1, busy0}), 32'd0);
        random_cfg();
        do_start(1'b1);
        wait_idle(500);

`ifdef ETH_LATENCY_MEASURER_TX_COUNTER_EN
        reset_dut();
        check("count_rst0", tx_count0, 32'd0);
        for (int f = 0; f < 3; f++) begin
            random_cfg();
            do_start(1'b1);
            wait_idle(500);
        end
        check("count_three0", tx_count0, 32'd3);
        check("count_three1", tx_count1, 32'd3);
        reset_dut();
        check("count_rst_again", tx_count0, 32'd0);
`endif

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
